// File: rtl/ps2_kbd_tx_if.sv
// Character request handshake between the ASCII source and the PS/2 keyboard transmitter.
interface ps2_kbd_tx_if;
  logic       ascii_valid;
  logic [7:0] ascii_data;
  logic       ascii_ready;
  logic       busy;
  logic       unknown;

  modport master (output ascii_valid, ascii_data, input ascii_ready, busy, unknown);
  modport slave  (input ascii_valid, ascii_data, output ascii_ready, busy, unknown);
endinterface

// File: rtl/ps2_kbd_tx.sv
// PS/2 keyboard-side transmitter: ASCII 0-9/A-Z -> scan-code-set-2 frames on push-pull ps2_clk/ps2_dat.
// Define PS2_KBD_TX_BREAK_EN to send make, F0, make (press + release); otherwise make code only.
module ps2_kbd_tx #(
  parameter int CLK_HALF = 2500,
  parameter int BYTE_GAP = 5000
) (
  input  logic             clk,
  input  logic             rst_n,
  ps2_kbd_tx_if.slave      req,
  output logic             ps2_clk,
  output logic             ps2_dat
);

  localparam int PH_MAX = (CLK_HALF > BYTE_GAP) ? CLK_HALF : BYTE_GAP;
  localparam int PH_W   = $clog2(PH_MAX) + 1;

  typedef enum logic [1:0] {IDLE, BIT_HI, BIT_LO, GAP} state_e;

  state_e            state_q;
  logic [PH_W-1:0]   phase_q;
  logic [3:0]        bit_q;
  logic [7:0]        scan_q;
  logic              ps2_clk_q;
  logic              ps2_dat_q;
  logic              ready_q;
  logic              unknown_q;

  logic              lut_hit;
  logic [7:0]        lut_code;
  logic [7:0]        cur_byte;
  logic              last_byte;
  logic              half_end;
  logic              gap_end;

  // ASCII -> set-2 make code; mirrors the on-board decoder's table
  always_comb begin
    lut_hit  = 1'b1;
    lut_code = 8'h00;
    case (req.ascii_data)
      8'h30: lut_code = 8'h45;
      8'h31: lut_code = 8'h16;
      8'h32: lut_code = 8'h1E;
      8'h33: lut_code = 8'h26;
      8'h34: lut_code = 8'h25;
      8'h35: lut_code = 8'h2E;
      8'h36: lut_code = 8'h36;
      8'h37: lut_code = 8'h3D;
      8'h38: lut_code = 8'h3E;
      8'h39: lut_code = 8'h46;
      8'h41: lut_code = 8'h1C;
      8'h42: lut_code = 8'h32;
      8'h43: lut_code = 8'h21;
      8'h44: lut_code = 8'h23;
      8'h45: lut_code = 8'h24;
      8'h46: lut_code = 8'h2B;
      8'h47: lut_code = 8'h34;
      8'h48: lut_code = 8'h33;
      8'h49: lut_code = 8'h43;
      8'h4A: lut_code = 8'h3B;
      8'h4B: lut_code = 8'h42;
      8'h4C: lut_code = 8'h4B;
      8'h4D: lut_code = 8'h3A;
      8'h4E: lut_code = 8'h31;
      8'h4F: lut_code = 8'h44;
      8'h50: lut_code = 8'h4D;
      8'h51: lut_code = 8'h15;
      8'h52: lut_code = 8'h2D;
      8'h53: lut_code = 8'h1B;
      8'h54: lut_code = 8'h2C;
      8'h55: lut_code = 8'h3C;
      8'h56: lut_code = 8'h2A;
      8'h57: lut_code = 8'h1D;
      8'h58: lut_code = 8'h22;
      8'h59: lut_code = 8'h35;
      8'h5A: lut_code = 8'h1A;
      default: lut_hit = 1'b0;
    endcase
  end

  // Frame bit idx of byte b: start 0, data LSB first, odd parity, stop 1
  function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] idx);
    if (idx == 4'd0)       return 1'b0;
    else if (idx <= 4'd8)  return b[3'(idx - 4'd1)];
    else if (idx == 4'd9)  return ~^b;
    else                   return 1'b1;
  endfunction

`ifdef PS2_KBD_TX_BREAK_EN
  logic [1:0] byte_q;
  assign cur_byte  = (byte_q == 2'd1) ? 8'hF0 : scan_q;
  assign last_byte = (byte_q == 2'd2);
`else
  assign cur_byte  = scan_q;
  assign last_byte = 1'b1;
`endif

  assign half_end = (phase_q == PH_W'(CLK_HALF - 1));
  assign gap_end  = (phase_q == PH_W'(BYTE_GAP - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      bit_q     <= '0;
      scan_q    <= '0;
      ps2_clk_q <= 1'b1;
      ps2_dat_q <= 1'b1;
      ready_q   <= 1'b1;
      unknown_q <= 1'b0;
`ifdef PS2_KBD_TX_BREAK_EN
      byte_q    <= '0;
`endif
    end else begin
      unknown_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req.ascii_valid && ready_q) begin
            if (lut_hit) begin
              // start bit goes out on the transfer edge itself
              scan_q    <= lut_code;
              state_q   <= BIT_HI;
              phase_q   <= '0;
              bit_q     <= '0;
              ps2_clk_q <= 1'b1;
              ps2_dat_q <= 1'b0;
              ready_q   <= 1'b0;
`ifdef PS2_KBD_TX_BREAK_EN
              byte_q    <= '0;
`endif
            end else begin
              unknown_q <= 1'b1;
            end
          end
        end
        BIT_HI: begin
          if (half_end) begin
            state_q   <= BIT_LO;
            phase_q   <= '0;
            ps2_clk_q <= 1'b0;
          end else begin
            phase_q <= phase_q + PH_W'(1);
          end
        end
        BIT_LO: begin
          if (half_end) begin
            phase_q   <= '0;
            ps2_clk_q <= 1'b1;
            if (bit_q == 4'd10) begin
              state_q   <= GAP;
              ps2_dat_q <= 1'b1;
            end else begin
              // data only moves while the clock is high
              state_q   <= BIT_HI;
              bit_q     <= bit_q + 4'd1;
              ps2_dat_q <= frame_bit(cur_byte, bit_q + 4'd1);
            end
          end else begin
            phase_q <= phase_q + PH_W'(1);
          end
        end
        GAP: begin
          if (gap_end) begin
            phase_q <= '0;
            if (last_byte) begin
              state_q <= IDLE;
              ready_q <= 1'b1;
            end else begin
              state_q   <= BIT_HI;
              bit_q     <= '0;
              ps2_dat_q <= 1'b0;
`ifdef PS2_KBD_TX_BREAK_EN
              byte_q    <= byte_q + 2'd1;
`endif
            end
          end else begin
            phase_q <= phase_q + PH_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req.ascii_ready = ready_q;
  assign req.busy        = ~ready_q;
  assign req.unknown     = unknown_q;
  assign ps2_clk         = ps2_clk_q;
  assign ps2_dat         = ps2_dat_q;

  a_dat_stable_clk_low: assert property (@(posedge clk) disable iff (!rst_n)
    (!ps2_clk_q && !$past(ps2_clk_q)) |-> $stable(ps2_dat_q));
  a_idle_lines_high: assert property (@(posedge clk) disable iff (!rst_n)
    ready_q |-> (ps2_clk_q && ps2_dat_q));

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Scoreboard bench for ps2_kbd_tx: stimulus queues expected frame bytes, a line monitor decodes and compares.
module tb_ps2_kbd_tx;
  localparam int CH   = 4;
  localparam int BG   = 8;
  localparam int SLOT = 22 * CH + BG;
`ifdef PS2_KBD_TX_BREAK_EN
  localparam int NB = 3;
`else
  localparam int NB = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ps2_clk, ps2_dat;

  ps2_kbd_tx_if bus();

  ps2_kbd_tx #(.CLK_HALF(CH), .BYTE_GAP(BG)) dut (
    .clk(clk), .rst_n(rst_n), .req(bus), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: character table straight from the scan-code set
  string KEYS = "0123456789ABCDEFGHIJKLMNOPQRSTUVWXYZ";
  byte unsigned CODES [36] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
                               8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
                               8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
                               8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};

  function automatic bit ref_lookup(input byte unsigned ch, output byte unsigned code);
    code = 8'h00;
    for (int i = 0; i < 36; i++)
      if (KEYS[i] == ch) begin
        code = CODES[i];
        return 1'b1;
      end
    return 1'b0;
  endfunction

  byte unsigned exp_q[$];
  int unk_exp = 0;

  // Line monitor: decode frames on ps2_clk falling edges
  logic [10:0] bits;
  int  nbits = 0;
  int  idle_cnt = 1000;
  int  fall_cnt = 0;
  logic mprev_clk = 1'b1, mprev_dat = 1'b1, prev_unk = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      nbits = 0; idle_cnt = 1000; mprev_clk = 1'b1; mprev_dat = 1'b1; prev_unk = 1'b0;
    end else begin
      check("busy_is_not_ready", bus.busy, !bus.ascii_ready);
      if (!ps2_clk && !mprev_clk) check("dat_stable_while_clk_low", ps2_dat, mprev_dat);
      if (mprev_clk && !ps2_clk) begin
        fall_cnt++;
        if (nbits == 0) check("idle_before_frame_ge_gap", idle_cnt >= BG, 1);
        bits[nbits] = ps2_dat;
        nbits++;
        if (nbits == 11) begin
          check("start_bit", bits[0], 0);
          check("stop_bit", bits[10], 1);
          check("odd_parity", $countones(bits[9:1]) % 2, 1);
          if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_frame: got 0x%0h, expected no frame", bits[8:1]);
          end else begin
            check("frame_byte", bits[8:1], exp_q.pop_front());
          end
          nbits = 0;
          idle_cnt = 0;
        end
      end else if (ps2_clk && ps2_dat && nbits == 0) begin
        idle_cnt++;
      end
      if (bus.unknown) begin
        check("unknown_expected", unk_exp > 0, 1);
        check("unknown_one_cycle", prev_unk, 0);
        if (unk_exp > 0) unk_exp--;
      end
      prev_unk  = bus.unknown;
      mprev_clk = ps2_clk;
      mprev_dat = ps2_dat;
    end
  end

  int last_xfer = 0;
  bit b2b = 1'b0;

  // mode 0: release valid and check completion; 1: keep valid high; 2: release and return
  task automatic send(input byte unsigned ch, input int mode);
    byte unsigned code;
    bit known;
    int budget, t0, rdy_cyc;
    known = ref_lookup(ch, code);
    @(negedge clk);
    bus.ascii_valid = 1'b1;
    bus.ascii_data  = ch;
    budget = 0;
    while (!bus.ascii_ready && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    if (!bus.ascii_ready) begin
      check("ready_timeout", 0, 1);
      bus.ascii_valid = 1'b0;
      b2b = 1'b0;
      return;
    end
    rdy_cyc = cyc;
    if (known) begin
      exp_q.push_back(code);
      if (NB == 3) begin
        exp_q.push_back(8'hF0);
        exp_q.push_back(code);
      end
    end else begin
      unk_exp++;
    end
    @(posedge clk);
    #1;
    t0 = cyc;
    if (b2b) begin
      check("b2b_ready_latency", rdy_cyc - last_xfer, NB * SLOT);
      check("b2b_xfer_first_ready_cycle", t0, rdy_cyc + 1);
    end
    last_xfer = t0;
    b2b = (mode == 1) && known;
    if (mode == 1) return;
    @(negedge clk);
    bus.ascii_valid = 1'b0;
    if (mode == 2) return;
    if (known) begin
      budget = 0;
      while (!bus.ascii_ready && budget < 2000) begin
        @(negedge clk);
        budget++;
      end
      check("ready_latency", cyc - t0, NB * SLOT);
    end else begin
      for (int i = 0; i < 4; i++) begin
        check("unknown_ready_stays", bus.ascii_ready, 1);
        check("unknown_lines_idle", {ps2_clk, ps2_dat}, 2'b11);
        @(negedge clk);
      end
    end
  endtask

  function automatic byte unsigned rand_unknown();
    byte unsigned c, dummy;
    do c = 8'($urandom_range(0, 255)); while (ref_lookup(c, dummy));
    return c;
  endfunction

  initial begin
    int order [36];
    int f, budget, fc;
    bus.ascii_valid = 1'b0;
    bus.ascii_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ps2_clk", ps2_clk, 1);
    check("rst_ps2_dat", ps2_dat, 1);
    check("rst_ready", bus.ascii_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_unknown", bus.unknown, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_ready", bus.ascii_ready, 1);

    send(8'h41, 0);                     // 'A'
    send(8'h21, 0);                     // '!'
    send(8'h61, 0);                     // 'a'
    send(8'h5A, 1);                     // 'Z', valid held
    send(8'h42, 0);                     // 'B' back-to-back

    // reset during bit 4 of the second frame (or the only frame)
    f = (NB > 1) ? 1 : 0;
    send(8'h59, 2);                     // 'Y'
    budget = 0;
    while (cyc < last_xfer + f * SLOT + 9 * CH && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    #1 rst_n = 1'b0;
    #1;
    check("midrst_ps2_clk", ps2_clk, 1);
    check("midrst_ps2_dat", ps2_dat, 1);
    check("midrst_busy", bus.busy, 0);
    check("midrst_ready", bus.ascii_ready, 1);
    exp_q.delete();
    b2b = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fc = fall_cnt;
    repeat (200) @(negedge clk);
    check("no_edges_after_rst", fall_cnt, fc);
    send(8'h39, 0);                     // '9'

    // all 36 characters in random order, random unknowns and back-to-back mixed in
    for (int i = 0; i < 36; i++) order[i] = i;
    for (int i = 35; i > 0; i--) begin
      int j, t;
      j = $urandom_range(0, i);
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    for (int i = 0; i < 36; i++) begin
      if ($urandom_range(0, 3) == 0) send(rand_unknown(), 0);
      send(KEYS[order[i]], (i == 35) ? 0 : int'($urandom_range(0, 1)));
    end

    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    check("unknown_all_seen", unk_exp, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
